// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   APB4 requester. Accepts one command at a time on a valid/ready command
//   port and runs it as an APB SETUP/ACCESS transfer. The read data and the
//   error/timeout status come back on a valid/ready response port.
//
//   Ports
//     PCLK, PRESETn         APB clock, asynchronous active-low reset
//     cmd_*                 command request (valid/ready), write/addr/wdata/strb
//     rsp_*                 response (valid/ready), rdata/slverr/timeout
//     PADDR..PSTRB          APB requester outputs
//     PRDATA/PREADY/PSLVERR APB completer inputs
//
//   All outputs are driven from flops. Each control flop is loaded from a
//   decode of the next state, so it changes on the same edge as the state.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
  // response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  // APB requester
  output logic [ADDR_WIDTH-1:0]     PADDR,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [DATA_WIDTH-1:0]     PWDATA,
  output logic [DATA_WIDTH/8-1:0]   PSTRB,
  input  logic [DATA_WIDTH-1:0]     PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  // Counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
  } cmd_t;

  // registered state
  state_t                r_state;
  cmd_t                  r_cmd;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_slverr;
  logic                  r_rsp_timeout;

  // next-state values
  state_t                w_state_nxt;
  cmd_t                  w_cmd_nxt;
  logic [CNT_W-1:0]      w_wait_nxt;
  logic                  w_psel_nxt;
  logic                  w_penable_nxt;
  logic                  w_cmd_ready_nxt;
  logic                  w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
  logic                  w_rsp_slverr_nxt;
  logic                  w_rsp_timeout_nxt;
  logic                  w_timeout_hit;

  // This PREADY-low cycle is the one that brings wait_cnt up to the limit.
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State and output registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= S_IDLE;
      r_cmd         <= '0;
      r_wait_cnt    <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd         <= w_cmd_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_slverr  <= w_rsp_slverr_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_cmd_nxt         = r_cmd;
    w_wait_nxt        = r_wait_cnt;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_slverr_nxt  = r_rsp_slverr;
    w_rsp_timeout_nxt = r_rsp_timeout;

    case (r_state)
      S_IDLE: begin
        // r_cmd_ready also guards the first cycle after reset release.
        if (cmd_valid && r_cmd_ready) begin
          w_cmd_nxt.write = cmd_write;
          w_cmd_nxt.addr  = cmd_addr;
          w_cmd_nxt.wdata = cmd_wdata;
          w_cmd_nxt.strb  = cmd_write ? cmd_strb : '0;
          w_state_nxt     = S_SETUP;
        end
      end

      S_SETUP: begin
        w_wait_nxt  = '0;
        w_state_nxt = S_ACCESS;
      end

      S_ACCESS: begin
        // A completion in the limit cycle takes priority over the timeout.
        if (PREADY) begin
          w_rsp_rdata_nxt   = r_cmd.write ? '0 : PRDATA;
          w_rsp_slverr_nxt  = PSLVERR;
          w_rsp_timeout_nxt = 1'b0;
          w_state_nxt       = S_RESP;
        end else begin
          w_wait_nxt = r_wait_cnt + CNT_W'(1);
          if (w_timeout_hit) begin
            w_rsp_rdata_nxt   = '0;
            w_rsp_slverr_nxt  = 1'b1;
            w_rsp_timeout_nxt = 1'b1;
            w_state_nxt       = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_psel_nxt      = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
    w_penable_nxt   = (w_state_nxt == S_ACCESS);
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == S_RESP);
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;

  // Address-phase signals come from the captured command and hold between transfers.
  assign PADDR   = r_cmd.addr;
  assign PWRITE  = r_cmd.write;
  assign PWDATA  = r_cmd.wdata;
  assign PSTRB   = r_cmd.strb;
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge. Each transfer's expected
//   bus timing and response are computed from the transfer description
//   (wait states, slave data, error flag, response back-pressure).
module tb_apb_master_bridge;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int checks   = 0;
  int failures = 0;

  apb_master_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_bus(input string tag, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [SW-1:0] st);
    chk({tag, "_paddr"},  PADDR,  addr);
    chk({tag, "_pwrite"}, PWRITE, wr);
    chk({tag, "_pwdata"}, PWDATA, wd);
    chk({tag, "_pstrb"},  PSTRB,  wr ? st : '0);
  endtask

  task automatic chk_rsp(input string tag, input logic [DW-1:0] rd, input logic err, input logic to);
    chk({tag, "_rsp_valid"},   rsp_valid,   1'b1);
    chk({tag, "_rsp_rdata"},   rsp_rdata,   rd);
    chk({tag, "_rsp_slverr"},  rsp_slverr,  err);
    chk({tag, "_rsp_timeout"}, rsp_timeout, to);
    chk({tag, "_psel"},        PSEL,        1'b0);
    chk({tag, "_penable"},     PENABLE,     1'b0);
    chk({tag, "_cmd_ready"},   cmd_ready,   1'b0);
  endtask

  // One complete transfer. Called and returns at a falling edge.
  // waits = number of PREADY-low ACCESS cycles the slave inserts before completing.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input int waits, input logic [DW-1:0] prd,
                         input logic serr, input int hold, input logic early_next);
    logic          to;
    int            acc;
    int            n;
    logic [DW-1:0] exp_rd;
    logic          exp_err;

    to      = (waits >= int'(TO));
    acc     = to ? int'(TO) : waits + 1;
    exp_rd  = (wr || to) ? '0 : prd;
    exp_err = to ? 1'b1 : serr;

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_strb  = st;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end

    // Accepted on the next rising edge; scramble inputs to prove capture.
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    cmd_strb  = SW'($urandom);
    chk("setup_psel",      PSEL,      1'b1);
    chk("setup_penable",   PENABLE,   1'b0);
    chk("setup_cmd_ready", cmd_ready, 1'b0);
    chk("setup_rsp_valid", rsp_valid, 1'b0);
    chk_bus("setup", wr, addr, wd, st);

    for (int k = 0; k < acc; k++) begin
      @(negedge PCLK);
      chk("access_psel",      PSEL,      1'b1);
      chk("access_penable",   PENABLE,   1'b1);
      chk("access_rsp_valid", rsp_valid, 1'b0);
      chk_bus("access", wr, addr, wd, st);
      if (k == waits) begin
        PREADY  = 1'b1;
        PRDATA  = prd;
        PSLVERR = serr;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = DW'($urandom);
        PSLVERR = 1'($urandom);
      end
    end

    @(negedge PCLK);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = DW'($urandom);
    chk_rsp("resp", exp_rd, exp_err, to);
    chk_bus("resp", wr, addr, wd, st);

    for (int h = 0; h < hold; h++) begin
      if (early_next) begin
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        cmd_strb  = SW'($urandom);
      end
      @(negedge PCLK);
      chk_rsp("hold", exp_rd, exp_err, to);
    end

    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", rsp_valid, 1'b0);
    chk("done_cmd_ready", cmd_ready, 1'b1);
    chk("done_psel",      PSEL,      1'b0);
    chk_bus("done", wr, addr, wd, st);
  endtask

  initial begin
    int waits;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    #12;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_psel",      PSEL,      1'b0);
    chk("rst_penable",   PENABLE,   1'b0);
    chk("rst_paddr",     PADDR,     '0);
    chk("rst_pwdata",    PWDATA,    '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Directed cases
    run_txn(1'b1, 8'h10, 32'hA5A5_5A5A, 4'hF, 0, 32'h1234_5678, 1'b0, 0, 1'b0);
    run_txn(1'b0, 8'h04, 32'h0BAD_F00D, 4'h3, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    run_txn(1'b0, 8'h20, 32'h0,         4'h0, 0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_txn(1'b0, 8'h30, 32'h0,         4'h0, 40, 32'h5555_AAAA, 1'b0, 0, 1'b0);
    run_txn(1'b1, 8'h31, 32'h7777_0000, 4'h5, 16, 32'h0, 1'b0, 0, 1'b0);
    run_txn(1'b0, 8'h32, 32'h0,         4'h0, 15, 32'hCAFE_0015, 1'b0, 0, 1'b0);
    run_txn(1'b1, 8'h40, 32'h1111_2222, 4'h9, 1, 32'h0, 1'b0, 5, 1'b1);
    run_txn(1'b0, 8'h44, 32'h0,         4'h0, 0, 32'h4444_4444, 1'b0, 0, 1'b0);

    // Reset in the middle of an ACCESS phase
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h55;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("mid_access_penable", PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_rst_psel",      PSEL,      1'b0);
    chk("mid_rst_penable",   PENABLE,   1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk("mid_rst_paddr",     PADDR,     '0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      chk("post_mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("post_mid_rst_psel",      PSEL,      1'b0);
      chk("post_mid_rst_cmd_ready", cmd_ready, 1'b1);
    end
    run_txn(1'b1, 8'h66, 32'h6666_9999, 4'hC, 2, 32'h0, 1'b0, 1, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0:       waits = 15;
        1:       waits = 16;
        2:       waits = int'($urandom_range(17, 20));
        default: waits = int'($urandom_range(0, 4));
      endcase
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom), waits,
              DW'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    cmd_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
